// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: FSM encoding and default sizing.
package adder_arbiter_pkg;

  localparam int DEF_NOF_BITS = 8;
  localparam int DEF_NOF_REQ  = 4;
  localparam int DEF_TIMEOUT  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Bundle of requester, shared-adder and response signals for adder_arbiter.
//
// Handshakes: a requester transfer happens on a rising edge where
// req_valid[i] & req_ready[i]; a response transfer happens on a rising edge
// where resp_valid & resp_ready. The producer keeps valid and its payload
// stable until the transfer edge. The adder side is a start/done pair:
// add_start is held with stable operands until add_done is seen.
interface adder_arbiter_if
  import adder_arbiter_pkg::*;
#(
  parameter int NOF_BITS = DEF_NOF_BITS,
  parameter int NOF_REQ  = DEF_NOF_REQ
);

  logic [NOF_REQ-1:0]          req_valid;
  logic [NOF_REQ-1:0]          req_ready;
  logic [NOF_REQ*NOF_BITS-1:0] req_a;
  logic [NOF_REQ*NOF_BITS-1:0] req_b;
  logic                        add_start;
  logic [NOF_BITS-1:0]         add_a;
  logic [NOF_BITS-1:0]         add_b;
  logic [NOF_BITS-1:0]         add_sum;
  logic                        add_done;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [$clog2(NOF_REQ)-1:0]  resp_id;
  logic [NOF_BITS-1:0]         resp_data;
  logic                        resp_err;
  logic [15:0]                 op_count;
  state_t                      fsm_state;

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, add_sum, add_done, resp_ready,
    output req_ready, add_start, add_a, add_b,
    output resp_valid, resp_id, resp_data, resp_err, op_count, fsm_state
  );

  // Requesters, adder and response consumer side.
  modport master (
    output req_valid, req_a, req_b, add_sum, add_done, resp_ready,
    input  req_ready, add_start, add_a, add_b,
    input  resp_valid, resp_id, resp_data, resp_err, op_count, fsm_state
  );

endinterface

// File: rtl/adder_arbiter_rr_select.sv
// Round-robin one-hot grant: search starts just after the last granted index.
module rr_select #(
  parameter int NOF_REQ = 4,
  parameter int IDW     = $clog2(NOF_REQ)
) (
  input  logic [NOF_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NOF_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id
);

  logic           found;
  logic [IDW-1:0] idx;

  // First requester found walking from last_grant+1 around the ring wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NOF_REQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NOF_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external adder among NOF_REQ requesters with round-robin
// arbitration, an add_done timeout and a response handshake.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NOF_BITS = DEF_NOF_BITS,
  parameter int NOF_REQ  = DEF_NOF_REQ,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input logic             clk,
  input logic             rst,
  adder_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(NOF_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  state_t              state;
  logic [IDW-1:0]      last_grant;
  logic [CW-1:0]       wait_cnt;
  logic [CW-1:0]       wait_cnt_next;
  logic [NOF_REQ-1:0]  grant;
  logic [IDW-1:0]      grant_id;
  logic [NOF_BITS-1:0] a_arr [NOF_REQ];
  logic [NOF_BITS-1:0] b_arr [NOF_REQ];

  logic                add_start_r;
  logic [NOF_BITS-1:0] add_a_r;
  logic [NOF_BITS-1:0] add_b_r;
  logic                resp_valid_r;
  logic [IDW-1:0]      resp_id_r;
  logic [NOF_BITS-1:0] resp_data_r;
  logic                resp_err_r;
  logic [15:0]         op_count_r;

  for (genvar g = 0; g < NOF_REQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[g*NOF_BITS +: NOF_BITS];
    assign b_arr[g] = bus.req_b[g*NOF_BITS +: NOF_BITS];
  end

  rr_select #(.NOF_REQ(NOF_REQ), .IDW(IDW)) u_rr_select (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign wait_cnt_next = wait_cnt + CW'(1);

  // Requests are only offered a grant while idle.
  assign bus.req_ready  = (state == IDLE) ? grant : '0;
  assign bus.add_start  = add_start_r;
  assign bus.add_a      = add_a_r;
  assign bus.add_b      = add_b_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_id    = resp_id_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.op_count   = op_count_r;
  assign bus.fsm_state  = state;

  // Arbitration FSM: accept, drive the adder until done or timeout, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IDW'(NOF_REQ - 1);
      wait_cnt     <= '0;
      add_start_r  <= 1'b0;
      add_a_r      <= '0;
      add_b_r      <= '0;
      resp_valid_r <= 1'b0;
      resp_id_r    <= '0;
      resp_data_r  <= '0;
      resp_err_r   <= 1'b0;
      op_count_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            add_a_r     <= a_arr[grant_id];
            add_b_r     <= b_arr[grant_id];
            resp_id_r   <= grant_id;
            last_grant  <= grant_id;
            wait_cnt    <= '0;
            add_start_r <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= wait_cnt_next;
          if (bus.add_done) begin
            resp_data_r  <= bus.add_sum;
            resp_err_r   <= 1'b0;
            add_start_r  <= 1'b0;
            resp_valid_r <= 1'b1;
            state        <= RESP;
          end else if (wait_cnt_next == CW'(TIMEOUT)) begin
            resp_data_r  <= '0;
            resp_err_r   <= 1'b1;
            add_start_r  <= 1'b0;
            resp_valid_r <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            op_count_r   <= op_count_r + 16'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a one-cycle adder model and a
// response scoreboard.
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int NB = 8;
  localparam int NR = 4;
  localparam int TO = 15;
  localparam int W  = 1 + 2 + NB;

  logic clk = 1'b0;
  logic rst;
  logic adder_en;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_count;

  // Clock and reset block.
  always #5 clk = ~clk;

  adder_arbiter_if #(.NOF_BITS(NB), .NOF_REQ(NR)) bus ();

  adder_arbiter #(.NOF_BITS(NB), .NOF_REQ(NR), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One-cycle adder; adder_en=0 models an adder that never answers.
  always @(posedge clk) begin
    bus.add_done <= adder_en & bus.add_start;
    bus.add_sum  <= bus.add_a + bus.add_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Requester id gets a/b; the others get random operands.
  task automatic load_operands(input int id, input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [NR*NB-1:0] va, vb;
    for (int i = 0; i < NR; i++) begin
      va[i*NB +: NB] = (i == id) ? a : NB'($urandom_range(0, 255));
      vb[i*NB +: NB] = (i == id) ? b : NB'($urandom_range(0, 255));
    end
    bus.req_a = va;
    bus.req_b = vb;
  endtask

  // Drive one request, expect requester id to win, wait for and check the response.
  task automatic run_op(input logic [NR-1:0] mask, input int id, input logic [NB-1:0] a,
                        input logic [NB-1:0] b, input logic err, input bit hold, input int bp);
    logic [NB-1:0] sum;
    logic [W-1:0]  exp, got;
    int n;
    sum = a + b;
    load_operands(id, a, b);
    bus.resp_ready = (bp == 0);
    bus.req_valid  = mask;
    #1;
    check("grant", bus.req_ready, 32'(4'b0001 << id));
    exp = {err, 2'(id), err ? NB'(0) : sum};
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.req_valid = '0;
    #1;
    check("add_start_issue", bus.add_start, 1);
    check("add_a", bus.add_a, a);
    check("add_b", bus.add_b, b);
    check("req_ready_busy", bus.req_ready, 0);
    n = 0;
    while (!bus.resp_valid && n < TO + 5) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("resp_seen", bus.resp_valid, 1);
    check("latency", n, err ? TO : 2);
    if (!bus.resp_valid) begin
      void'(exp_q.pop_back());
      return;
    end
    got = {bus.resp_err, bus.resp_id, bus.resp_data};
    exp = exp_q.pop_front();
    check("resp", got, exp);
    check("add_start_resp", bus.add_start, 0);
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      #1;
      check("bp_hold", {bus.resp_valid, bus.resp_err, bus.resp_id, bus.resp_data}, {1'b1, exp});
      check("bp_req_ready", bus.req_ready, 0);
      check("bp_op_count", bus.op_count, exp_count);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    #1;
    exp_count++;
    check("op_count", bus.op_count, exp_count);
    check("resp_drop", bus.resp_valid, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    #1;
  endtask

  initial begin
    logic seen;
    rst            = 1'b1;
    adder_en       = 1'b1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    exp_count      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state.
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_add_start", bus.add_start, 0);
    check("rst_add_ab", {bus.add_a, bus.add_b}, 0);
    check("rst_resp", {bus.resp_valid, bus.resp_err, bus.resp_id, bus.resp_data}, 0);
    check("rst_op_count", bus.op_count, 0);
    check("rst_state", bus.fsm_state, IDLE);

    // Single operation and 8-bit wrap of the sum.
    run_op(4'b0001, 0, 8'h12, 8'h34, 1'b0, 1'b0, 0);
    run_op(4'b0001, 0, 8'hFF, 8'h02, 1'b0, 1'b0, 0);

    // Fairness from a fresh reset: 0,1,2,3,0 with all requesters held.
    pulse_reset();
    check("rst2_op_count", bus.op_count, 0);
    for (int i = 0; i < 5; i++)
      run_op(4'b1111, i % NR, NB'($urandom_range(0, 255)), NB'($urandom_range(0, 255)),
             1'b0, (i < 4), 0);

    // Adder never answers, then a normal request proceeds.
    adder_en = 1'b0;
    run_op(4'b0100, 2, 8'h55, 8'h66, 1'b1, 1'b0, 0);
    adder_en = 1'b1;
    run_op(4'b1000, 3, 8'h80, 8'h80, 1'b0, 1'b0, 0);

    // Response backpressure for 5 cycles; last grant was 3 so 0 wins.
    run_op(4'b0011, 0, 8'h0A, 8'h0B, 1'b0, 1'b1, 5);
    bus.req_valid = '0;

    // Reset in the middle of an issue.
    adder_en = 1'b0;
    load_operands(1, 8'h21, 8'h43);
    bus.req_valid = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("mid_add_start", bus.add_start, 1);
    repeat (2) @(negedge clk);
    pulse_reset();
    check("mid_rst_add_start", bus.add_start, 0);
    check("mid_rst_resp_valid", bus.resp_valid, 0);
    check("mid_rst_op_count", bus.op_count, 0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      seen = seen | bus.resp_valid;
    end
    check("mid_rst_no_resp", seen, 0);
    adder_en = 1'b1;
    run_op(4'b1111, 0, 8'h33, 8'h44, 1'b0, 1'b0, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter NOF_BITS, default 8, operand/sum width.
REQ-002 SHALL have parameter NOF_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter TIMEOUT, default 15, max cycles waited for add_done.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  NOF_REQ  per-requester operation request.
REQ-007 SHALL have port req_ready  output  NOF_REQ  per-requester accept, at most one bit high.
REQ-008 SHALL have port req_a  input  NOF_REQ*NOF_BITS  operand A, requester i at slice [i*NOF_BITS +: NOF_BITS].
REQ-009 SHALL have port req_b  input  NOF_REQ*NOF_BITS  operand B, same packing.
REQ-010 SHALL have port add_start  output  1  start strobe to shared adder.
REQ-011 SHALL have ports add_a, add_b  output  NOF_BITS  operands to shared adder.
REQ-012 SHALL have port add_sum  input  NOF_BITS  adder result.
REQ-013 SHALL have port add_done  input  1  adder result valid.
REQ-014 SHALL have port resp_valid  output  1  response valid.
REQ-015 SHALL have port resp_ready  input  1  response consumer accept.
REQ-016 SHALL have ports resp_id  output  clog2(NOF_REQ)  granted requester; resp_data  output  NOF_BITS  sum; resp_err  output  1  timeout flag.
REQ-017 SHALL have port op_count  output  16  completed responses, wraps at 65535->0.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-019 IDLE: req_ready = one-hot round-robin grant over req_valid (combinational); no request -> all zero, stay IDLE.
REQ-020 Round-robin: priority search starts at last_grant+1 mod NOF_REQ; last_grant updated only on accept.
REQ-021 On accept edge: latch requester operands into add_a/add_b, id into resp_id, clear wait counter, go ISSUE.
REQ-022 ISSUE: add_start held 1, add_a/add_b stable; wait counter increments each cycle.
REQ-023 ISSUE with add_done=1: capture add_sum into resp_data, resp_err=0, go RESP; add_start low from next cycle.
REQ-024 ISSUE with counter reaching TIMEOUT and add_done=0: resp_data=0, resp_err=1, go RESP.
REQ-025 add_done sampled only in ISSUE; add_done in IDLE/RESP ignored.
REQ-026 RESP: resp_valid=1, resp_id/resp_data/resp_err stable until resp_valid&resp_ready edge; then op_count+1, go IDLE.
REQ-027 No request accepted in ISSUE or RESP (req_ready all zero); back-to-back accept possible in the IDLE cycle after response handshake.
REQ-028 Arithmetic: arbiter passes add_sum unmodified; sum modulo 2^NOF_BITS, no carry reported.
REQ-029 Latency with one-cycle adder: accept edge T, add_start high cycle T+1..T+2, resp_valid high from cycle T+3 (after edge T+2 capture... exactly 2 edges after accept).
REQ-030 req_valid dropping after accept has no effect on the operation in flight.

Reset
REQ-031 rst=1 at edge: state IDLE, last_grant=NOF_REQ-1 (requester 0 first priority), add_start=0, add_a=add_b=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, op_count=0, wait counter=0.
REQ-032 rst mid-ISSUE or mid-RESP SHALL abandon the operation with no response and no op_count increment.

Structure
REQ-033 Shared package SHALL hold state encoding (IDLE/ISSUE/RESP) and default NOF_BITS, NOF_REQ, TIMEOUT constants.
REQ-034 One sub-module rr_select SHALL compute one-hot grant from request vector and last_grant; all sequential logic in adder_arbiter.

Verification
REQ-035 Single: req_valid=0001, a=0x12, b=0x34 -> add_a=0x12, add_b=0x34, resp_id=0, resp_data=0x46, resp_err=0, op_count=1.
REQ-036 Overflow: a=0xFF, b=0x02 -> resp_data=0x01, resp_err=0.
REQ-037 Fairness: req_valid=1111 held, resp_ready=1 -> grant order 0,1,2,3,0; each requester served once per 4 responses.
REQ-038 Timeout: add_done tied 0 -> resp_valid after TIMEOUT cycles in ISSUE with resp_err=1, resp_data=0; next request proceeds normally.
REQ-039 Backpressure: resp_ready=0 for 5 cycles -> resp fields stable, req_ready=0, op_count unchanged until handshake.
REQ-040 Reset mid-ISSUE: rst pulse -> add_start=0, resp_valid never asserted, op_count unchanged, next grant to requester 0.
